// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor: start request, operands, status and result.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             BIN;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   S;
    logic             V;

    // Requester side: drives the operands and start, observes status and result.
    modport master (
        output start, A, B, BIN,
        input  busy, done, S, V
    );

    // Subtractor side.
    modport slave (
        input  start, A, B, BIN,
        output busy, done, S, V
    );
endinterface

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: S = A - B - BIN, DIGIT bits per cycle, LSD first, registered borrow.
// Takes WIDTH/DIGIT compute cycles followed by a one-cycle DONE state carrying the done pulse.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input logic           clk,
    input logic           rst,
    serial_subtractor_if.slave bus
);

    localparam int unsigned N    = WIDTH / DIGIT;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             borrow_q, borrow_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH:0]   s_q, s_d;
    logic             v_q, v_d;
    // Operand sign bits kept aside because the operand registers shift out as digits are consumed.
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;

    logic [DIGIT:0]         diff;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0]       res_shift;
    logic                   last_digit;

    // One digit step: borrow-out lands in the top bit of diff, difference digit enters from the top.
    always_comb begin
        diff       = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow_q};
        res_cat    = {diff[DIGIT-1:0], res_q};
        res_shift  = res_cat[WIDTH+DIGIT-1:DIGIT];
        last_digit = (cnt_q == CntW'(N - 1));
    end

    // Next-state: accept in IDLE/DONE, step digits in RUN, publish S/V on the last digit.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        s_d      = s_q;
        v_d      = v_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;

        case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    a_d      = bus.A;
                    b_d      = bus.B;
                    borrow_d = bus.BIN;
                    a_msb_d  = bus.A[WIDTH-1];
                    b_msb_d  = bus.B[WIDTH-1];
                    cnt_d    = '0;
                    state_d  = StRun;
                end else begin
                    state_d  = StIdle;
                end
            end
            StRun: begin
                a_d      = a_q >> DIGIT;
                b_d      = b_q >> DIGIT;
                borrow_d = diff[DIGIT];
                res_d    = res_shift;
                cnt_d    = cnt_q + 1'b1;
                if (last_digit) begin
                    s_d     = {diff[DIGIT], res_shift};
                    v_d     = (a_msb_q != b_msb_q) && (res_shift[WIDTH-1] != a_msb_q);
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset; reset also clears the published result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            s_q      <= '0;
            v_q      <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            s_q      <= s_d;
            v_q      <= v_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
        end
    end

    assign bus.busy = (state_q == StRun);
    assign bus.done = (state_q == StDone);
    assign bus.S    = s_q;
    assign bus.V    = v_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and swept checks of serial_subtractor at 4/1 and 8/{1,2,4,8} (WIDTH/DIGIT).
module tb_serial_subtractor;

    logic clk;
    logic rst;

    int n_cmp;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 4-bit, 1-bit-digit instance.
    logic       st4, bin4;
    logic [3:0] a4, b4;
    serial_subtractor_if #(.WIDTH(4)) if4 ();
    assign if4.start = st4;
    assign if4.A     = a4;
    assign if4.B     = b4;
    assign if4.BIN   = bin4;

    serial_subtractor #(.WIDTH(4), .DIGIT(1)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4)
    );

    // 8-bit instances sharing one stimulus; index i has DIGIT = 1 << i.
    logic       st8, bin8;
    logic [7:0] a8, b8;
    logic [8:0] s8    [4];
    logic       v8    [4];
    logic       busy8 [4];
    logic       done8 [4];

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_w8
            serial_subtractor_if #(.WIDTH(8)) bus8 ();
            assign bus8.start = st8;
            assign bus8.A     = a8;
            assign bus8.B     = b8;
            assign bus8.BIN   = bin8;
            assign s8[g]      = bus8.S;
            assign v8[g]      = bus8.V;
            assign busy8[g]   = bus8.busy;
            assign done8[g]   = bus8.done;

            serial_subtractor #(.WIDTH(8), .DIGIT(1 << g)) u_dut8 (
                .clk (clk),
                .rst (rst),
                .bus (bus8)
            );
        end
    endgenerate

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
        logic [4:0] s;
        logic       v;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Launch one 4-bit operation, scramble the operands right after acceptance,
    // return the negedge index (1 = first after the accepting edge) where done appeared.
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                        output int lat);
        lat = 0;
        @(negedge clk);
        st4 = 1'b1; a4 = a; b4 = b; bin4 = bin;
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                st4 = 1'b0; a4 = ~a; b4 = ~b; bin4 = ~bin;
            end
            if (if4.done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    // Bounded-time guard.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, lat2, busy_cnt, dcnt_abort;
        int         lat8 [4];
        int         dcnt [4];
        logic [7:0] ra, rb;
        logic       rbin;
        logic [8:0] exp_s;
        logic       exp_v;

        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        st4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        st8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;

        vecs[0] = '{a: 4'd2, b: 4'd0,  bin: 1'b0, s: 5'h02, v: 1'b0};
        vecs[1] = '{a: 4'd0, b: 4'd15, bin: 1'b0, s: 5'h11, v: 1'b0};
        vecs[2] = '{a: 4'd1, b: 4'd14, bin: 1'b0, s: 5'h13, v: 1'b0};
        vecs[3] = '{a: 4'd7, b: 4'd8,  bin: 1'b0, s: 5'h1F, v: 1'b1};
        vecs[4] = '{a: 4'd5, b: 4'd5,  bin: 1'b1, s: 5'h1F, v: 1'b0};
        vecs[5] = '{a: 4'd5, b: 4'd5,  bin: 1'b0, s: 5'h00, v: 1'b0};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy4", {31'd0, if4.busy}, 32'd0);
        chk("rst_done4", {31'd0, if4.done}, 32'd0);
        chk("rst_s4",    {27'd0, if4.S},    32'd0);
        chk("rst_v4",    {31'd0, if4.V},    32'd0);
        chk("rst_busy8", {31'd0, busy8[1]}, 32'd0);
        chk("rst_s8",    {23'd0, s8[1]},    32'd0);
        rst = 1'b0;

        // Table-driven 4-bit vectors; latency is N+1 = 5.
        for (int i = 0; i < 6; i++) begin
            run4(vecs[i].a, vecs[i].b, vecs[i].bin, lat);
            chk($sformatf("vec%0d_lat", i), lat, 32'd5);
            chk($sformatf("vec%0d_s", i), {27'd0, if4.S}, {27'd0, vecs[i].s});
            chk($sformatf("vec%0d_v", i), {31'd0, if4.V}, {31'd0, vecs[i].v});
        end

        // start pulsed with other operands during RUN is ignored.
        @(negedge clk);
        st4 = 1'b1; a4 = 4'd2; b4 = 4'd0; bin4 = 1'b0;
        @(posedge clk);
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) st4 = 1'b0;
            if (k == 2) begin
                st4 = 1'b1; a4 = 4'd9; b4 = 4'd3; bin4 = 1'b1;
            end
            if (k == 3) st4 = 1'b0;
            if (if4.done === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk("ignore_lat", lat, 32'd5);
        chk("ignore_s", {27'd0, if4.S}, 32'h02);
        chk("ignore_v", {31'd0, if4.V}, 32'd0);
        @(negedge clk);
        chk("ignore_idle", {30'd0, if4.busy, if4.done}, 32'd0);

        // Abort: leave V=1, S=1F, then reset mid-operation.
        run4(4'd7, 4'd8, 1'b0, lat);
        chk("pre_abort_v", {31'd0, if4.V}, 32'd1);
        @(negedge clk);
        st4 = 1'b1; a4 = 4'd0; b4 = 4'd15; bin4 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        st4 = 1'b0;
        @(negedge clk);
        chk("abort_busy_before", {31'd0, if4.busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'd0, if4.busy}, 32'd0);
        chk("abort_s",    {27'd0, if4.S},    32'd0);
        chk("abort_v",    {31'd0, if4.V},    32'd0);
        dcnt_abort = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (if4.done === 1'b1) dcnt_abort++;
        end
        chk("abort_no_done", dcnt_abort, 32'd0);

        // 8/2 with start held high: back-to-back operations.
        @(negedge clk);
        st8 = 1'b1; a8 = 8'h00; b8 = 8'h01; bin8 = 1'b0;
        @(posedge clk);
        lat = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (busy8[1] === 1'b1) busy_cnt++;
            if (done8[1] === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk("b2b_lat1", lat, 32'd5);
        chk("b2b_busy_cycles", busy_cnt, 32'd4);
        chk("b2b_s1", {23'd0, s8[1]}, 32'h1FF);
        chk("b2b_v1", {31'd0, v8[1]}, 32'd0);
        a8 = 8'h80; b8 = 8'h01;
        lat2 = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("b2b_done_pulse", {31'd0, done8[1]}, 32'd0);
                chk("b2b_rebusy", {31'd0, busy8[1]}, 32'd1);
                chk("b2b_s_hold", {23'd0, s8[1]}, 32'h1FF);
            end
            if (done8[1] === 1'b1) begin
                lat2 = k;
                break;
            end
        end
        chk("b2b_lat2", lat2, 32'd5);
        chk("b2b_s2", {23'd0, s8[1]}, 32'h07F);
        chk("b2b_v2", {31'd0, v8[1]}, 32'd1);
        st8 = 1'b0;
        @(negedge clk);
        chk("b2b_idle", {30'd0, busy8[1], done8[1]}, 32'd0);
        repeat (12) @(negedge clk);

        // Swept operations against the reference model on all four digit sizes.
        for (int op = 0; op < 1000; op++) begin
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            rbin = 1'($urandom_range(0, 1));
            exp_s = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
            exp_v = (ra[7] != rb[7]) && (exp_s[7] != ra[7]);
            for (int i = 0; i < 4; i++) begin
                lat8[i] = 0;
                dcnt[i] = 0;
            end
            @(negedge clk);
            st8 = 1'b1; a8 = ra; b8 = rb; bin8 = rbin;
            @(posedge clk);
            for (int k = 1; k <= 11; k++) begin
                @(negedge clk);
                if (k == 1) begin
                    st8 = 1'b0; a8 = ~ra; b8 = ~rb;
                end
                for (int i = 0; i < 4; i++) begin
                    if (done8[i] === 1'b1) begin
                        dcnt[i]++;
                        if (lat8[i] == 0) lat8[i] = k;
                    end
                end
            end
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("sweep%0d_d%0d_lat", op, 1 << i), lat8[i], (8 >> i) + 1);
                chk($sformatf("sweep%0d_d%0d_pulses", op, 1 << i), dcnt[i], 32'd1);
                chk($sformatf("sweep%0d_d%0d_s", op, 1 << i), {23'd0, s8[i]}, {23'd0, exp_s});
                chk($sformatf("sweep%0d_d%0d_v", op, 1 << i), {31'd0, v8[i]}, {31'd0, exp_v});
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
